// File: rtl/decode_pkg.sv
// Shared decode constants: immediate-extender select codes, RV32I opcodes and the
// decoded-instruction buffer entry layout.
package decode_pkg;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_S    = 3'd1;
    localparam logic [2:0] IMM_J    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_B    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [2:0]  sel;
        logic [24:0] imm_inp;
        logic [31:0] pc;
        logic        illegal;
    } dec_entry_t;

    localparam int unsigned DEC_ENTRY_W = $bits(dec_entry_t);

    // Returns {illegal, sel}; R-type has no immediate but is legal.
    function automatic logic [3:0] decode_opcode(input logic [6:0] op);
        logic [3:0] res;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: res = {1'b0, IMM_I};
            OP_STORE:                 res = {1'b0, IMM_S};
            OP_JAL:                   res = {1'b0, IMM_J};
            OP_LUI, OP_AUIPC:         res = {1'b0, IMM_U};
            OP_BRANCH:                res = {1'b0, IMM_B};
            OP_REG:                   res = {1'b0, IMM_NONE};
            default:                  res = {1'b1, IMM_NONE};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// Power-of-two circular buffer with synchronous flush; flush beats a same-cycle pop.
module decode_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage front: opcode decode at enqueue, decoded-instruction buffer, RUN/HALT control.
// Define DECODE_ILLEGAL_TRAP_EN to halt intake after an illegal opcode until flush.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_imm_sel,
    output logic [24:0] out_imm_inp,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic        out_illegal
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic       state, state_next;
    logic       push, pop, full, empty;
    logic [3:0] dec_code;
    dec_entry_t wentry, head;

    assign dec_code        = decode_opcode(in_instr[6:0]);
    assign wentry.sel      = dec_code[2:0];
    assign wentry.imm_inp  = in_instr[31:7];
    assign wentry.pc       = in_pc;
    // Without the trap the flag is never stored, so out_illegal stays 0.
    assign wentry.illegal  = TRAP_EN & dec_code[3];

    assign in_ready  = !rst && !full && (state == ST_RUN) && !flush;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    decode_fifo #(
        .WIDTH (DEC_ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_RUN;
        end else if (push && wentry.illegal) begin
            state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    always_comb begin
        out_imm_sel = IMM_NONE;
        out_imm_inp = '0;
        out_pc      = '0;
        out_rd      = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_imm_sel = head.sel;
            out_imm_inp = head.imm_inp;
            out_pc      = head.pc;
            out_rd      = head.imm_inp[4:0];
            out_rs1     = head.imm_inp[12:8];
            out_rs2     = head.imm_inp[17:13];
            out_illegal = head.illegal;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: opcode table, directed corner sequences, random traffic
// checked against a queue-based model. Honours DECODE_ILLEGAL_TRAP_EN.
module tb_decode_ctrl;

    localparam int unsigned DEPTH = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc;
    logic [2:0]  out_imm_sel;
    logic [24:0] out_imm_inp;
    logic [4:0]  out_rd, out_rs1, out_rs2;

    decode_ctrl #(.BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm_sel (out_imm_sel),
        .out_imm_inp (out_imm_inp),
        .out_pc      (out_pc),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } model_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic        illegal;
    } vec_t;

    model_t mq[$];
    bit     halted;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction class -> immediate format, straight from the RV32I encoding table.
    function automatic logic [2:0] ref_sel(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd0;
        if (op == 7'h23) return 3'd1;
        if (op == 7'h6F) return 3'd2;
        if (op == 7'h37 || op == 7'h17) return 3'd3;
        if (op == 7'h63) return 3'd4;
        return 3'd7;
    endfunction

    function automatic bit ref_illegal(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        return !(op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h6F, 7'h37, 7'h17, 7'h63, 7'h33});
    endfunction

    // One clock cycle: drive at negedge, check mid-low phase, update model at posedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl);
        logic   exp_vld, exp_rdy;
        model_t h;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        #2;
        exp_vld = (mq.size() != 0);
        exp_rdy = (mq.size() < DEPTH) && !halted && !fl;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
        if (exp_vld) begin
            h = mq[0];
            chk("imm_sel", {29'd0, out_imm_sel}, {29'd0, ref_sel(h.instr)});
            chk("imm_inp", {7'd0, out_imm_inp}, h.instr >> 7);
            chk("pc", out_pc, h.pc);
            chk("rd", {27'd0, out_rd}, {27'd0, h.instr[11:7]});
            chk("rs1", {27'd0, out_rs1}, {27'd0, h.instr[19:15]});
            chk("rs2", {27'd0, out_rs2}, {27'd0, h.instr[24:20]});
            chk("illegal", {31'd0, out_illegal}, {31'd0, TRAP && ref_illegal(h.instr)});
        end else begin
            chk("idle_sel", {29'd0, out_imm_sel}, 32'd7);
            chk("idle_data", {out_imm_inp, out_rd, out_rs1, out_rs2, out_illegal} == '0
                             && out_pc == '0 ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge clk);
        if (fl) begin
            mq.delete();
            halted = 1'b0;
        end else begin
            if (exp_vld && ordy) void'(mq.pop_front());
            if (v && exp_rdy) begin
                mq.push_back('{instr: ins, pc: p});
                if (TRAP && ref_illegal(ins)) halted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    vec_t        vecs[$];
    logic [6:0]  ops[11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h6F, 7'h37, 7'h17, 7'h63, 7'h33,
                             7'h7F, 7'h0B};
    logic [31:0] rnd;

    initial begin
        vecs.push_back('{32'h00500093, 3'd0, 1'b0});  // addi x1,x0,5
        vecs.push_back('{32'h00412183, 3'd0, 1'b0});  // lw
        vecs.push_back('{32'h000080E7, 3'd0, 1'b0});  // jalr
        vecs.push_back('{32'h00112023, 3'd1, 1'b0});  // sw
        vecs.push_back('{32'h0080006F, 3'd2, 1'b0});  // jal
        vecs.push_back('{32'h123450B7, 3'd3, 1'b0});  // lui
        vecs.push_back('{32'h00001517, 3'd3, 1'b0});  // auipc
        vecs.push_back('{32'h00208463, 3'd4, 1'b0});  // beq
        vecs.push_back('{32'h002081B3, 3'd7, 1'b0});  // add
        vecs.push_back('{32'h0000007F, 3'd7, 1'b1});  // unsupported
        vecs.push_back('{32'hFFFFFFFF, 3'd7, 1'b1});  // unsupported

        in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; halted = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sel", {29'd0, out_imm_sel}, 32'd7);
        @(negedge clk);
        rst = 1'b0;

        // Opcode table, one instruction at a time.
        foreach (vecs[i]) begin
            step(1, vecs[i].instr, 32'h1000 + 4 * i, 1, 0);
            chk("tbl_sel", {29'd0, out_imm_sel}, {29'd0, vecs[i].sel});
            chk("tbl_illegal", {31'd0, out_illegal}, {31'd0, TRAP && vecs[i].illegal});
            if (i == 0) begin
                chk("addi_imm_inp", {7'd0, out_imm_inp}, 32'h000A001);
                chk("addi_rd", {27'd0, out_rd}, 32'd1);
            end
            step(0, 0, 0, 1, 0);
            step(0, 0, 0, 0, 1);
        end

        // Backpressure: sw, beq fill the buffer, jal waits.
        step(1, 32'h00112023, 32'h200, 0, 0);
        step(1, 32'h00208463, 32'h204, 0, 0);
        chk("bp_head_sw", {29'd0, out_imm_sel}, 32'd1);
        step(1, 32'h0080006F, 32'h208, 0, 0);
        step(1, 32'h0080006F, 32'h208, 1, 0);
        chk("bp_head_beq", {29'd0, out_imm_sel}, 32'd4);
        step(1, 32'h0080006F, 32'h208, 1, 0);
        chk("bp_head_jal", {29'd0, out_imm_sel}, 32'd2);
        chk("bp_jal_pc", out_pc, 32'h208);
        step(0, 0, 0, 1, 0);

        // Flush with a full buffer and a pending input.
        step(1, 32'h00500093, 32'h300, 0, 0);
        step(1, 32'h00500093, 32'h304, 0, 0);
        step(1, 32'h00112023, 32'h308, 1, 1);
        chk("flush_empty", {31'd0, out_valid}, 32'd0);
        step(0, 0, 0, 1, 0);

        // Illegal opcode.
        step(1, 32'h0000007F, 32'h400, 0, 0);
        chk("ill_flag", {31'd0, out_illegal}, {31'd0, TRAP});
        chk("ill_sel", {29'd0, out_imm_sel}, 32'd7);
        step(1, 32'h00500093, 32'h404, 0, 0);
        step(1, 32'h00500093, 32'h408, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(1, 32'h00500093, 32'h40C, 1, 0);
        step(0, 0, 0, 1, 0);

        // Asynchronous reset with two entries buffered.
        step(1, 32'h00500093, 32'h500, 0, 0);
        step(1, 32'h00112023, 32'h504, 0, 0);
        in_valid = 0;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        mq.delete();
        halted = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h123450B7, 32'h600, 1, 0);
        chk("arst_lui_sel", {29'd0, out_imm_sel}, 32'd3);
        step(0, 0, 0, 1, 0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rnd = $urandom();
            step(($urandom_range(0, 3) != 0),
                 {rnd[31:7], ops[$urandom_range(0, 10)]},
                 $urandom(),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
